hms_timekeeper: RTL and testbench
=================================

Name: hms_timekeeper

Overview:
- Parametrised, single-clock-domain successor to the min/sec clock core: a seconds/minutes/hours timekeeper with a setup mode.
- Contains its own 1 Hz prescaler, pushbutton debounce with press-edge detection, a mode/position FSM, carry-chained counters and a blink mask for the field being edited.
- All counters advance on synchronous clock enables, never on derived clocks.
- Outputs feed the existing two-digit splitter, segment decoder and display scanner unchanged.

Parameters:
- CLK_HZ, 50000000, clk cycles per second; prescaler terminal count is CLK_HZ-1.
- DEB_CYC, 500000, clk cycles between debounce samples (10 ms at 50 MHz).
- BLINK_DIV, 12500000, clk cycles per blink phase half-period.
- HOUR_MAX, 23, last hour value before wrap (11 for a 12-slot dial starting at 0).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- i_sw_mode  in  1  raw pushbutton, active-low; toggles CLOCK/SETUP
- i_sw_pos  in  1  raw pushbutton, active-low; selects field in SETUP
- i_sw_inc  in  1  raw pushbutton, active-low; increments selected field in SETUP
- i_clr  in  1  synchronous clear, active-high
- o_sec  out  6  seconds 0..59
- o_min  out  6  minutes 0..59
- o_hour  out  5  hours 0..HOUR_MAX
- o_mode  out  1  0=CLOCK, 1=SETUP
- o_pos  out  2  0=SEC, 1=MIN, 2=HOUR; 3 never driven
- o_blink_mask  out  3  {hour,min,sec}; 1 = blank that field now
- o_tick  out  1  one-cycle pulse per counted second
- o_day_pulse  out  1  one-cycle pulse on HOUR_MAX:59:59 -> 0:00:00 rollover

Behaviour:
- Reset: clk and rst_n are the clock and reset; rst_n is asynchronous, active-low. Every output and internal register resets to 0. Debounce state resets to "released".
- Prescaler: counts 0..CLK_HZ-1 in CLOCK mode. At CLK_HZ-1 it wraps to 0 and o_tick=1 for that cycle.
- Prescaler hold: in SETUP the prescaler is held at 0 and o_tick=0.
- Debounce:
  - A sample strobe fires every DEB_CYC cycles.
  - Each raw input passes through a 2-flop synchroniser, then is sampled on the strobe.
  - The debounced level becomes "pressed" after 2 consecutive low samples and "released" after 2 consecutive high samples.
  - A press event is a one-clk pulse on the released->pressed transition. Holding a button gives no repeat.
- FSM, CLOCK state:
  - mode press -> SETUP, with o_pos forced to SEC.
  - pos and inc presses are ignored.
- FSM, SETUP state:
  - mode press -> CLOCK; the prescaler restarts from 0, so the first tick comes CLK_HZ cycles later.
  - pos press: SEC->MIN->HOUR->SEC.
  - inc press: increments the selected field only, with wrap (59->0, HOUR_MAX->0) and no carry into the next field.
- Simultaneous press events, in priority order:
  - mode wins; pos/inc in the same cycle are dropped.
  - pos before inc: if both fire, pos advances and inc is dropped.
- Counting in CLOCK, on o_tick:
  - sec++; at 59 -> 0 with a carry into min.
  - min at 59 with carry -> 0, carry into hour.
  - hour at HOUR_MAX with carry -> 0, and o_day_pulse=1 in the same cycle the counters wrap.
- Output timing: all counter outputs are registered; a new value appears the cycle after the enabling event.
- i_clr:
  - Zeroes sec/min/hour and the prescaler.
  - o_mode/o_pos are unchanged.
  - Overrides a coincident tick or inc; no o_day_pulse.
- Blink:
  - A free-running phase bit toggles every BLINK_DIV cycles and resets to 0.
  - In SETUP, the o_blink_mask bit for the selected field equals the phase; the other bits are 0.
  - In CLOCK, o_blink_mask=0.
- Reset mid-operation: asynchronous return to CLOCK, 0:00:00; any pending press is discarded.

Test Plan (CLK_HZ=10, DEB_CYC=2, BLINK_DIV=4, HOUR_MAX=23):
- Release rst_n, run 600 clk -> o_tick pulses every 10 clk; o_sec ends at 0, o_min=1, o_hour=0.
- Preload by setup to 23:59:58, return to CLOCK, run 20 clk -> 23:59:59, then 0:00:00 with o_day_pulse high exactly 1 cycle, coincident with the wrap.
- Hold i_sw_mode low 1 sample (2 clk), then release -> no mode change. Hold it low 6 clk -> o_mode=1, o_pos=0, o_tick stays 0 while in SETUP.
- In SETUP: pos press ×2 -> o_pos=2. With hour=23, inc press -> o_hour=0, min/sec unchanged. Hold inc 100 clk -> exactly one increment.
- In SETUP, pos=MIN -> o_blink_mask toggles 3'b010/3'b000 every 4 clk. Mode press -> mask 0; the first o_tick arrives 10 clk after the exit.
- i_clr asserted on the same cycle as o_tick at 5:06:07 -> outputs 0:00:00 next cycle, o_mode unchanged. Assert rst_n low mid-SETUP -> all outputs 0 immediately.

Source files
------------

// File: rtl/hms_timekeeper.sv
// Seconds/minutes/hours timekeeper with 1 Hz prescaler, debounced buttons,
// CLOCK/SETUP mode FSM, field editing and blink mask for the edited field.

module hms_debounce (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_n_i,
   input  logic strobe_i,
   output logic press_o
);
   // Everything is kept as "pressed" polarity so reset value 0 means released.
   logic [1:0] sync_q;
   logic       samp_q;
   logic       lvl_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         samp_q <= 1'b0;
         lvl_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], ~raw_n_i};
         if (strobe_i) begin
            samp_q <= sync_q[1];
            if (sync_q[1] == samp_q) lvl_q <= sync_q[1];
         end
      end
   end

   assign press_o = strobe_i & sync_q[1] & samp_q & ~lvl_q;
endmodule

module hms_timekeeper #(
   parameter int CLK_HZ    = 50000000,
   parameter int DEB_CYC   = 500000,
   parameter int BLINK_DIV = 12500000,
   parameter int HOUR_MAX  = 23
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_sw_mode,
   input  logic       i_sw_pos,
   input  logic       i_sw_inc,
   input  logic       i_clr,
   output logic [5:0] o_sec,
   output logic [5:0] o_min,
   output logic [4:0] o_hour,
   output logic       o_mode,
   output logic [1:0] o_pos,
   output logic [2:0] o_blink_mask,
   output logic       o_tick,
   output logic       o_day_pulse
);
   localparam int PW = (CLK_HZ    > 1) ? $clog2(CLK_HZ)    : 1;
   localparam int DW = (DEB_CYC   > 1) ? $clog2(DEB_CYC)   : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [4:0] HMAX = 5'(HOUR_MAX);
   localparam logic [1:0] POS_SEC = 2'd0, POS_MIN = 2'd1, POS_HOUR = 2'd2;
   localparam int B_MODE = 0, B_POS = 1, B_INC = 2;

   typedef enum logic {CLOCK = 1'b0, SETUP = 1'b1} mode_e;

   mode_e         state_q, state_d;
   logic [1:0]    pos_q, pos_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [5:0]    sec_q, sec_d, min_q, min_d;
   logic [4:0]    hour_q, hour_d;
   logic          day_q, day_d;
   logic [DW-1:0] deb_cnt_q;
   logic [BW-1:0] blk_cnt_q;
   logic          phase_q;
   logic          strobe, tick;
   logic [2:0]    raw_n, press;

   assign strobe = (deb_cnt_q == DW'(DEB_CYC - 1));
   assign tick   = (state_q == CLOCK) && (pre_q == PW'(CLK_HZ - 1));
   assign raw_n  = {i_sw_inc, i_sw_pos, i_sw_mode};

   for (genvar g = 0; g < 3; g++) begin : g_deb
      hms_debounce u_deb (
         .clk      (clk),
         .rst_n    (rst_n),
         .raw_n_i  (raw_n[g]),
         .strobe_i (strobe),
         .press_o  (press[g])
      );
   end

   always_comb begin
      state_d = state_q;
      pos_d   = pos_q;
      pre_d   = pre_q;
      sec_d   = sec_q;
      min_d   = min_q;
      hour_d  = hour_q;
      day_d   = 1'b0;
      case (state_q)
         CLOCK: begin
            pre_d = tick ? '0 : pre_q + PW'(1);
            if (tick) begin
               if (sec_q == 6'd59) begin
                  sec_d = '0;
                  if (min_q == 6'd59) begin
                     min_d = '0;
                     if (hour_q == HMAX) begin
                        hour_d = '0;
                        day_d  = 1'b1;
                     end else begin
                        hour_d = hour_q + 5'd1;
                     end
                  end else begin
                     min_d = min_q + 6'd1;
                  end
               end else begin
                  sec_d = sec_q + 6'd1;
               end
            end
            if (press[B_MODE]) begin
               state_d = SETUP;
               pos_d   = POS_SEC;
            end
         end
         SETUP: begin
            // Held at zero so the first tick after exit is a full second away.
            pre_d = '0;
            if (press[B_MODE]) begin
               state_d = CLOCK;
            end else if (press[B_POS]) begin
               pos_d = (pos_q == POS_HOUR) ? POS_SEC : pos_q + 2'd1;
            end else if (press[B_INC]) begin
               case (pos_q)
                  POS_SEC:  sec_d  = (sec_q  == 6'd59) ? '0 : sec_q  + 6'd1;
                  POS_MIN:  min_d  = (min_q  == 6'd59) ? '0 : min_q  + 6'd1;
                  POS_HOUR: hour_d = (hour_q == HMAX)  ? '0 : hour_q + 5'd1;
                  default:  ;
               endcase
            end
         end
         default: state_d = CLOCK;
      endcase
      if (i_clr) begin
         sec_d  = '0;
         min_d  = '0;
         hour_d = '0;
         pre_d  = '0;
         day_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= CLOCK;
         pos_q     <= '0;
         pre_q     <= '0;
         sec_q     <= '0;
         min_q     <= '0;
         hour_q    <= '0;
         day_q     <= 1'b0;
         deb_cnt_q <= '0;
         blk_cnt_q <= '0;
         phase_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pos_q     <= pos_d;
         pre_q     <= pre_d;
         sec_q     <= sec_d;
         min_q     <= min_d;
         hour_q    <= hour_d;
         day_q     <= day_d;
         deb_cnt_q <= strobe ? '0 : deb_cnt_q + DW'(1);
         if (blk_cnt_q == BW'(BLINK_DIV - 1)) begin
            blk_cnt_q <= '0;
            phase_q   <= ~phase_q;
         end else begin
            blk_cnt_q <= blk_cnt_q + BW'(1);
         end
      end
   end

   assign o_sec        = sec_q;
   assign o_min        = min_q;
   assign o_hour       = hour_q;
   assign o_mode       = (state_q == SETUP);
   assign o_pos        = pos_q;
   assign o_tick       = tick;
   assign o_day_pulse  = day_q;
   assign o_blink_mask = {pos_q == POS_HOUR, pos_q == POS_MIN, pos_q == POS_SEC}
                         & {3{phase_q & (state_q == SETUP)}};
endmodule

// File: tb/tb_hms_timekeeper.sv
// Bench for hms_timekeeper: directed scenarios plus random button traffic,
// checked against a time-of-day model kept as seconds since midnight.

module tb_hms_timekeeper;
   localparam int CLK_HZ = 10, DEB_CYC = 2, BLINK_DIV = 4, HOUR_MAX = 23;
   localparam int DAY = (HOUR_MAX + 1) * 3600;

   logic       clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
   logic [2:0] raw_n = 3'b111;   // {inc, pos, mode}, active-low
   logic [5:0] o_sec, o_min;
   logic [4:0] o_hour;
   logic       o_mode, o_tick, o_day_pulse;
   logic [1:0] o_pos;
   logic [2:0] o_blink_mask;
   int checks = 0, errors = 0;

   hms_timekeeper #(.CLK_HZ(CLK_HZ), .DEB_CYC(DEB_CYC), .BLINK_DIV(BLINK_DIV), .HOUR_MAX(HOUR_MAX)) dut (
      .clk(clk), .rst_n(rst_n), .i_sw_mode(raw_n[0]), .i_sw_pos(raw_n[1]), .i_sw_inc(raw_n[2]),
      .i_clr(clr), .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour), .o_mode(o_mode), .o_pos(o_pos),
      .o_blink_mask(o_blink_mask), .o_tick(o_tick), .o_day_pulse(o_day_pulse)
   );

   always #5 clk = ~clk;

   wire [24:0] dut_v = {o_sec, o_min, o_hour, o_mode, o_pos, o_blink_mask, o_tick, o_day_pulse};
   wire [16:0] hms_v = {o_hour, o_min, o_sec};

   // Model: time as seconds of day; sample history for the debouncers.
   typedef struct {
      int t; int mode; int pos; int pre; int ecnt;
      bit day; bit [2:0] h1; bit [2:0] h2; bit [2:0] prv; bit [2:0] lvl;
   } mst_t;
   mst_t m;

   function automatic mst_t mstep(input mst_t s, input bit [2:0] pr, input bit c);
      mst_t n; bit [2:0] ev; bit tk; int hh, mm, ss;
      n = s; ev = '0;
      if (s.ecnt % DEB_CYC == DEB_CYC - 1)
         for (int b = 0; b < 3; b++) begin
            ev[b] = s.h2[b] && s.prv[b] && !s.lvl[b];
            if (s.h2[b] == s.prv[b]) n.lvl[b] = s.h2[b];
            n.prv[b] = s.h2[b];
         end
      n.h2 = s.h1; n.h1 = pr; n.ecnt = s.ecnt + 1; n.day = 1'b0;
      tk = (s.mode == 0) && (s.pre == CLK_HZ - 1);
      if (s.mode == 0) begin
         n.pre = tk ? 0 : s.pre + 1;
         if (tk) begin
            n.t = (s.t + 1) % DAY;
            n.day = (n.t == 0);
         end
         if (ev[0]) begin n.mode = 1; n.pos = 0; end
      end else begin
         n.pre = 0;
         if (ev[0]) n.mode = 0;
         else if (ev[1]) n.pos = (s.pos + 1) % 3;
         else if (ev[2]) begin
            hh = s.t / 3600; mm = (s.t / 60) % 60; ss = s.t % 60;
            case (s.pos)
               0: ss = (ss + 1) % 60;
               1: mm = (mm + 1) % 60;
               default: hh = (hh + 1) % (HOUR_MAX + 1);
            endcase
            n.t = hh * 3600 + mm * 60 + ss;
         end
      end
      if (c) begin n.t = 0; n.pre = 0; n.day = 1'b0; end
      return n;
   endfunction

   function automatic logic [24:0] mexp(input mst_t s);
      logic [2:0] mk; logic ph;
      mk = '0;
      ph = ((s.ecnt / BLINK_DIV) % 2) == 1;
      if (s.mode == 1) mk[s.pos] = ph;
      return {6'(s.t % 60), 6'((s.t / 60) % 60), 5'(s.t / 3600), 1'(s.mode), 2'(s.pos), mk,
              (s.mode == 0) && (s.pre == CLK_HZ - 1), s.day};
   endfunction

   always @(posedge clk or negedge rst_n)
      if (!rst_n) m <= '{default: 0};
      else        m <= mstep(m, ~raw_n, clr);

   task automatic press(input int b, input int hold);
      raw_n[b] = 1'b0;
      repeat (hold) @(negedge clk);
      raw_n[b] = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   // Returns at the first sample showing CLOCK mode.
   task automatic exit_setup();
      raw_n[0] = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (o_mode == 1'b0) break;
      end
      raw_n[0] = 1'b1;
      checks++;
      if (o_mode !== 1'b0) begin errors++; $display("FAIL exit_setup: mode %b required 0", o_mode); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (dut_v !== 25'd0) begin errors++; $display("FAIL reset_zero: got %h required 0", dut_v); end
      checks++;
      if (dut_v !== mexp(m)) begin errors++; $display("FAIL reset_model: got %h required %h", dut_v, mexp(m)); end
   endtask

   task automatic test_count();
      int nt = 0;
      rst_n = 1'b1;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         checks++;
         if (dut_v !== mexp(m)) begin errors++; $display("FAIL count_step %0d: got %h required %h", i, dut_v, mexp(m)); end
         if (o_tick) nt++;
      end
      checks++;
      if (nt != 60) begin errors++; $display("FAIL count_ticks: got %0d required 60", nt); end
      checks++;
      if (hms_v !== {5'd0, 6'd1, 6'd0}) begin errors++; $display("FAIL count_time: got %h required 0:01:00", hms_v); end
   endtask

   task automatic test_rollover();
      logic [16:0] prev; int npulse = 0, at = -1;
      press(0, 6);
      @(negedge clk); clr = 1'b1;
      @(negedge clk); clr = 1'b0;
      repeat (58) press(2, 6);
      press(1, 6);
      repeat (59) press(2, 6);
      press(1, 6);
      repeat (23) press(2, 6);
      checks++;
      if (hms_v !== {5'd23, 6'd59, 6'd58}) begin errors++; $display("FAIL preload: got %h required 23:59:58", hms_v); end
      checks++;
      if (dut_v !== mexp(m)) begin errors++; $display("FAIL preload_model: got %h required %h", dut_v, mexp(m)); end
      exit_setup();
      prev = hms_v;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (o_day_pulse) begin
            npulse++; at = i;
            checks++;
            if (hms_v !== 17'd0) begin errors++; $display("FAIL wrap_time: got %h required 0", hms_v); end
            checks++;
            if (prev !== {5'd23, 6'd59, 6'd59}) begin errors++; $display("FAIL pre_wrap: got %h required 23:59:59", prev); end
         end
         prev = hms_v;
      end
      checks++;
      if (npulse != 1 || at != 20) begin errors++; $display("FAIL day_pulse: got %0d pulses at %0d required 1 at 20", npulse, at); end
   endtask

   task automatic test_debounce();
      int nt = 0; logic [5:0] s0;
      repeat (10) @(negedge clk);
      raw_n[0] = 1'b0;
      repeat (2) @(negedge clk);
      raw_n[0] = 1'b1;
      repeat (12) @(negedge clk);
      checks++;
      if (o_mode !== 1'b0) begin errors++; $display("FAIL short_press: mode %b required 0", o_mode); end
      press(0, 6);
      checks++;
      if ({o_mode, o_pos} !== 3'b100) begin errors++; $display("FAIL enter_setup: got %b required 100", {o_mode, o_pos}); end
      s0 = o_sec;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (o_tick) nt++;
      end
      checks++;
      if (nt != 0 || o_sec !== s0) begin errors++; $display("FAIL setup_hold: got %0d ticks sec %0d required 0 ticks sec %0d", nt, o_sec, s0); end
   endtask

   task automatic test_setup_edit();
      logic [5:0] ss, mm;
      press(1, 6);
      press(1, 6);
      checks++;
      if (o_pos !== 2'd2) begin errors++; $display("FAIL pos_cycle: got %0d required 2", o_pos); end
      for (int i = 0; i < 30; i++) begin
         if (o_hour == 5'd23) break;
         press(2, 6);
      end
      checks++;
      if (o_hour !== 5'd23) begin errors++; $display("FAIL hour_reach: got %0d required 23", o_hour); end
      ss = o_sec; mm = o_min;
      press(2, 6);
      checks++;
      if (hms_v !== {5'd0, mm, ss}) begin errors++; $display("FAIL hour_wrap: got %h required %h", hms_v, {5'd0, mm, ss}); end
      raw_n[2] = 1'b0;
      repeat (100) @(negedge clk);
      raw_n[2] = 1'b1;
      repeat (8) @(negedge clk);
      checks++;
      if (o_hour !== 5'd1) begin errors++; $display("FAIL hold_inc: got %0d required 1", o_hour); end
      raw_n[2:1] = 2'b00;
      repeat (6) @(negedge clk);
      raw_n[2:1] = 2'b11;
      repeat (8) @(negedge clk);
      checks++;
      if ({o_pos, hms_v} !== {2'd0, 5'd1, mm, ss}) begin errors++; $display("FAIL pos_over_inc: got %h required %h", {o_pos, hms_v}, {2'd0, 5'd1, mm, ss}); end
      checks++;
      if (dut_v !== mexp(m)) begin errors++; $display("FAIL edit_model: got %h required %h", dut_v, mexp(m)); end
   endtask

   task automatic test_blink();
      logic [2:0] pm; int last = -1, nchg = 0, at = -1;
      press(1, 6);
      pm = o_blink_mask;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         checks++;
         if ((o_blink_mask !== 3'b000 && o_blink_mask !== 3'b010) || dut_v !== mexp(m)) begin
            errors++; $display("FAIL blink_val %0d: got %h required %h", i, dut_v, mexp(m));
         end
         if (o_blink_mask !== pm) begin
            if (last >= 0) begin
               checks++;
               if (i - last != 4) begin errors++; $display("FAIL blink_period: got %0d required 4", i - last); end
            end
            last = i; nchg++;
         end
         pm = o_blink_mask;
      end
      checks++;
      if (nchg != 6) begin errors++; $display("FAIL blink_count: got %0d required 6", nchg); end
      exit_setup();
      checks++;
      if (o_blink_mask !== 3'b000) begin errors++; $display("FAIL blink_clock: got %b required 000", o_blink_mask); end
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (o_tick) begin at = i; break; end
      end
      checks++;
      if (at != 9) begin errors++; $display("FAIL first_tick: got %0d required 9", at); end
   endtask

   task automatic test_clr();
      press(0, 6);
      @(negedge clk); clr = 1'b1;
      @(negedge clk); clr = 1'b0;
      repeat (7) press(2, 6);
      press(1, 6);
      repeat (6) press(2, 6);
      press(1, 6);
      repeat (5) press(2, 6);
      exit_setup();
      for (int i = 0; i < 20; i++) begin
         if (o_tick) break;
         @(negedge clk);
      end
      checks++;
      if ({o_tick, hms_v} !== {1'b1, 5'd5, 6'd6, 6'd7}) begin errors++; $display("FAIL clr_setup: got %h required tick at 5:06:07", {o_tick, hms_v}); end
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      checks++;
      if ({hms_v, o_mode, o_day_pulse} !== 19'd0) begin errors++; $display("FAIL clr_tick: got %h required 0", {hms_v, o_mode, o_day_pulse}); end
      checks++;
      if (dut_v !== mexp(m)) begin errors++; $display("FAIL clr_model: got %h required %h", dut_v, mexp(m)); end
   endtask

   task automatic test_reset_mid();
      press(0, 6);
      checks++;
      if (o_mode !== 1'b1) begin errors++; $display("FAIL rst_pre: mode %b required 1", o_mode); end
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (dut_v !== 25'd0) begin errors++; $display("FAIL async_reset: got %h required 0", dut_v); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         checks++;
         if (dut_v !== mexp(m)) begin errors++; $display("FAIL random %0d: got %h required %h", i, dut_v, mexp(m)); end
         for (int b = 0; b < 3; b++)
            if ($urandom_range(15) == 0) raw_n[b] = ~raw_n[b];
         clr = ($urandom_range(255) == 0);
      end
      raw_n = 3'b111;
      clr = 1'b0;
   endtask

   initial begin
      test_reset();
      test_count();
      test_rollover();
      test_debounce();
      test_setup_edit();
      test_blink();
      test_clr();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
